// File: rtl/class_binarize_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// class_binarize_ctrl_pkg
// Shared constants and types for the class binarization sequencer.
//   DIMS_PER_CC       dims per memory chunk
//   BITWIDTH_PER_DIM  width of one non-binary class counter
//   CLASS_BIT_THR     a counter strictly greater than this becomes a 1
//   NUM_CLASSES       default number of class hypervectors
//   NUM_CHUNKS        default number of chunks per hypervector
//   bin_state_t       sequencer FSM states
// -----------------------------------------------------------------------------
package class_binarize_ctrl_pkg;

  localparam int DIMS_PER_CC      = 8;
  localparam int BITWIDTH_PER_DIM = 4;
  localparam int CLASS_BIT_THR    = 3;
  localparam int NUM_CLASSES      = 10;
  localparam int NUM_CHUNKS       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bin_state_t;

endpackage

// File: rtl/class_thresholder.sv
// -----------------------------------------------------------------------------
// class_thresholder
// Combinational binarizer for one chunk of class counters. Output bit i is 1
// when counter i is strictly greater than CLASS_BIT_THR (unsigned). The output
// is forced to zero unless both en and binarize are high, so an idle write
// port presents clean zeros.
// Ports:
//   en        in  1                              chunk valid
//   binarize  in  1                              apply thresholding
//   counters  in  DIMS_PER_CC*BITWIDTH_PER_DIM   packed counters, dim 0 in LSBs
//   bits      out DIMS_PER_CC                    binarized chunk
// -----------------------------------------------------------------------------
module class_thresholder
  import class_binarize_ctrl_pkg::*;
(
  input  logic                                    en,
  input  logic                                    binarize,
  input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] counters,
  output logic [DIMS_PER_CC-1:0]                  bits
);

  localparam logic [BITWIDTH_PER_DIM-1:0] THR = BITWIDTH_PER_DIM'(CLASS_BIT_THR);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    bits = '0;
    if (en && binarize) begin
      for (int i = 0; i < DIMS_PER_CC; i++) begin
        bits[i] = counters[i*BITWIDTH_PER_DIM +: BITWIDTH_PER_DIM] > THR;
      end
    end
  end

endmodule

// File: rtl/class_binarize_ctrl.sv
// -----------------------------------------------------------------------------
// class_binarize_ctrl
// Walks every (class, chunk) pair, class outer / chunk inner, reading each
// chunk from the non-binary class memory, thresholding it and writing the
// binary chunk to the binary class memory. One chunk per cycle while
// wr_ready is high; a low wr_ready holds the pending write and pauses reads.
// Optional feature macro: CLASS_BIN_POPCOUNT_EN adds a per-class count of ones.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a pass (only honoured in IDLE)
//   abort                 cancel the pass, back to IDLE next cycle
//   busy                  pass in progress
//   done                  one-cycle pulse after the last write is accepted
//   rd_en/rd_class/rd_chunk/rd_data   non-binary memory read port
//                         (rd_data valid the cycle after rd_en, then held)
//   wr_en/wr_class/wr_chunk/wr_data   binary memory write port
//   wr_ready              binary memory accepts the write this cycle
//   pc_valid, pc_count    (CLASS_BIN_POPCOUNT_EN) per-class ones count
// -----------------------------------------------------------------------------
module class_binarize_ctrl #(
  parameter int NUM_CLASSES = class_binarize_ctrl_pkg::NUM_CLASSES,
  parameter int NUM_CHUNKS  = class_binarize_ctrl_pkg::NUM_CHUNKS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [$clog2(NUM_CLASSES)-1:0]  rd_class,
  output logic [$clog2(NUM_CHUNKS)-1:0]   rd_chunk,
  input  logic [class_binarize_ctrl_pkg::DIMS_PER_CC*
                class_binarize_ctrl_pkg::BITWIDTH_PER_DIM-1:0] rd_data,
  output logic                            wr_en,
  output logic [$clog2(NUM_CLASSES)-1:0]  wr_class,
  output logic [$clog2(NUM_CHUNKS)-1:0]   wr_chunk,
  output logic [class_binarize_ctrl_pkg::DIMS_PER_CC-1:0] wr_data,
  input  logic                            wr_ready
`ifdef CLASS_BIN_POPCOUNT_EN
  ,
  output logic                            pc_valid,
  output logic [$clog2(NUM_CHUNKS*class_binarize_ctrl_pkg::DIMS_PER_CC+1)-1:0] pc_count
`endif
);

  import class_binarize_ctrl_pkg::*;

  localparam int CW = $clog2(NUM_CLASSES);
  localparam int KW = $clog2(NUM_CHUNKS);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_CLASSES - 1);
  localparam logic [KW-1:0] LAST_K = KW'(NUM_CHUNKS - 1);

  bin_state_t     state;
  logic [CW-1:0]  rc, wc;
  logic [KW-1:0]  rk, wk;
  logic           rd_all;     // every chunk of the pass has been read
  logic           out_valid;  // rd_data holds a chunk not yet written

  logic rd_fire, wr_fire, last_wr;

  // A read may be issued when the output slot is empty or drains this cycle;
  // because memory holds rd_data, stalling the read never loses a chunk.
  assign rd_fire = (state == RUN) && !rd_all && (!out_valid || wr_ready);
  assign wr_fire = out_valid && wr_ready;
  assign last_wr = wr_fire && (wc == LAST_C) && (wk == LAST_K);

  assign rd_en    = rd_fire;
  assign rd_class = rc;
  assign rd_chunk = rk;
  assign wr_en    = out_valid;
  assign wr_class = wc;
  assign wr_chunk = wk;

  class_thresholder u_thr (
    .en       (out_valid),
    .binarize (out_valid),
    .counters (rd_data),
    .bits     (wr_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rc        <= '0;
      rk        <= '0;
      wc        <= '0;
      wk        <= '0;
      rd_all    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (rd_fire) begin
            if (rk == LAST_K) begin
              rk <= '0;
              if (rc == LAST_C) begin
                rc     <= '0;
                rd_all <= 1'b1;
              end else begin
                rc <= rc + CW'(1);
              end
            end else begin
              rk <= rk + KW'(1);
            end
          end

          // A chunk stays pending until accepted; a new read refills the slot.
          out_valid <= rd_fire || (out_valid && !wr_ready);

          if (wr_fire) begin
            if (wk == LAST_K) begin
              wk <= '0;
              wc <= (wc == LAST_C) ? '0 : wc + CW'(1);
            end else begin
              wk <= wk + KW'(1);
            end
          end

          if (last_wr) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            rd_all <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLASS_BIN_POPCOUNT_EN
  localparam int PCW = $clog2(NUM_CHUNKS*DIMS_PER_CC+1);

  logic [PCW-1:0] pc_acc, pc_hold, chunk_ones, pc_sum;

  // The first chunk of a class restarts the running sum.
  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < DIMS_PER_CC; i++) begin
      chunk_ones = chunk_ones + PCW'(wr_data[i]);
    end
    pc_sum = ((wk == '0) ? '0 : pc_acc) + chunk_ones;
  end

  // The pulse shows the total including the chunk accepted this cycle; the
  // held copy is shown between pulses.
  assign pc_valid = wr_fire && (wk == LAST_K);
  assign pc_count = pc_valid ? pc_sum : pc_hold;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      pc_acc  <= '0;
      pc_hold <= '0;
    end else if (wr_fire) begin
      pc_acc <= pc_sum;
      if (wk == LAST_K) pc_hold <= pc_sum;
    end
  end
`endif

endmodule

// File: tb/tb_class_binarize_ctrl.sv
module tb_class_binarize_ctrl;
  import class_binarize_ctrl_pkg::*;

  localparam int NC  = 2;
  localparam int NK  = 4;
  localparam int N   = NC * NK;
  localparam int DW  = DIMS_PER_CC * BITWIDTH_PER_DIM;

  logic                   clk = 1'b0;
  logic                   rst, start, abort, wr_ready;
  logic                   busy, done, rd_en, wr_en;
  logic [$clog2(NC)-1:0]  rd_class, wr_class;
  logic [$clog2(NK)-1:0]  rd_chunk, wr_chunk;
  logic [DW-1:0]          rd_data = '0;
  logic [DW-1:0]          rd_next = '0;
  logic [DIMS_PER_CC-1:0] wr_data;
`ifdef CLASS_BIN_POPCOUNT_EN
  logic                   pc_valid;
  logic [$clog2(NK*DIMS_PER_CC+1)-1:0] pc_count;
`endif

  always #5 clk = ~clk;

  class_binarize_ctrl #(.NUM_CLASSES(NC), .NUM_CHUNKS(NK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_class (rd_class),
    .rd_chunk (rd_chunk),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_class (wr_class),
    .wr_chunk (wr_chunk),
    .wr_data  (wr_data),
    .wr_ready (wr_ready)
`ifdef CLASS_BIN_POPCOUNT_EN
    ,
    .pc_valid (pc_valid),
    .pc_count (pc_count)
`endif
  );

  typedef struct {
    logic [DW-1:0]          counters;
    logic [DIMS_PER_CC-1:0] expected;
  } vec_t;

  typedef struct {
    int                     c;
    int                     k;
    logic [DIMS_PER_CC-1:0] d;
  } wr_t;

  typedef struct {
    int c;
    int k;
    int cnt;
  } pc_t;

  vec_t          tbl [N];
  logic [DW-1:0] mem [NC][NK];
  wr_t           wq[$];
  pc_t           pcq[$];
  int            done_cnt = 0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a [8];
    logic [DW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(a[i]);
    return r;
  endfunction

  // Reference: bit i set when the i-th counter value exceeds the threshold.
  function automatic logic [DIMS_PER_CC-1:0] thr_model(input logic [DW-1:0] c);
    logic [DIMS_PER_CC-1:0] b;
    int v;
    b = '0;
    for (int i = 0; i < DIMS_PER_CC; i++) begin
      v = int'((c >> (BITWIDTH_PER_DIM * i)) & DW'((1 << BITWIDTH_PER_DIM) - 1));
      b[i] = (v > CLASS_BIT_THR);
    end
    return b;
  endfunction

  // Memory models and observers, sampled mid-cycle when everything is stable.
  always @(negedge clk) begin
    if (rd_en) rd_next = mem[rd_class][rd_chunk];
    if (wr_en && wr_ready) wq.push_back('{int'(wr_class), int'(wr_chunk), wr_data});
    if (done) done_cnt++;
`ifdef CLASS_BIN_POPCOUNT_EN
    if (pc_valid) pcq.push_back('{int'(wr_class), int'(wr_chunk), int'(pc_count)});
`endif
  end

  always @(posedge clk) rd_data <= rd_next;

  // mode 0: wr_ready high; 1: hold off write (0,2) three cycles;
  // 2: random wr_ready; 3: extra start pulse while running.
  task automatic run_pass(input int mode, output int n);
    int stall_left;
    bit seen;
    stall_left = 3;
    n = 0;
    seen = 0;
    wq.delete();
    pcq.delete();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (n < 300) begin
      case (mode)
        1: begin
          if (wr_en && wr_class == 0 && wr_chunk == 2 && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
          end else begin
            wr_ready = 1'b1;
          end
        end
        2: wr_ready = ($urandom_range(0, 3) != 0);
        3: begin
          wr_ready = 1'b1;
          start = (n == 4);
        end
        default: wr_ready = 1'b1;
      endcase
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", busy, 1);
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    wr_ready = 1'b1;
    check("done_seen", seen, 1);
    if (seen) begin
      check("busy_low_at_done", busy, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic check_writes();
    check("wr_count", wq.size(), N);
    for (int i = 0; i < wq.size() && i < N; i++) begin
      check($sformatf("wr%0d_class", i), wq[i].c, i / NK);
      check($sformatf("wr%0d_chunk", i), wq[i].k, i % NK);
      check($sformatf("wr%0d_data", i), wq[i].d, thr_model(mem[i / NK][i % NK]));
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) mem[i / NK][i % NK] = tbl[i].counters;
  endtask

  initial begin
    int n;
    bit hit;

    tbl[0] = '{pk(0, 3, 4, 15, 3, 4, 1, 8),     8'b1010_1100};
    tbl[1] = '{pk(3, 3, 3, 3, 3, 3, 3, 3),      8'h00};
    tbl[2] = '{pk(4, 4, 4, 4, 4, 4, 4, 4),      8'hFF};
    tbl[3] = '{pk(15, 15, 15, 15, 15, 15, 15, 15), 8'hFF};
    tbl[4] = '{pk(0, 0, 0, 0, 0, 0, 0, 0),      8'h00};
    tbl[5] = '{pk(4, 0, 4, 0, 4, 0, 4, 0),      8'h55};
    tbl[6] = '{pk(3, 4, 3, 4, 3, 4, 3, 4),      8'hAA};
    tbl[7] = '{pk(15, 14, 13, 12, 2, 1, 0, 3),  8'h0F};
    load_table();

    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_class", rd_class, 0);
    check("rst_rd_chunk", rd_chunk, 0);
    check("rst_wr_class", wr_class, 0);
    check("rst_wr_chunk", wr_chunk, 0);
    check("rst_wr_data", wr_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven full pass.
    run_pass(0, n);
    check("latency_full", n, N + 2);
    check("done_pulses_full", done_cnt, 1);
    check_writes();
    for (int i = 0; i < wq.size() && i < N; i++)
      check($sformatf("tbl%0d_data", i), wq[i].d, tbl[i].expected);

    // Three-cycle write stall on chunk (0,2).
    run_pass(1, n);
    check("latency_stall", n, N + 2 + 3);
    check_writes();

    // Extra start while running is ignored.
    run_pass(3, n);
    check("latency_start_in_run", n, N + 2);
    check_writes();
    repeat (5) @(negedge clk);
    check("no_restart_busy", busy, 0);
    check("done_pulses_start_in_run", done_cnt, 1);

    // Random contents and random back-pressure against the model.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < NK; k++) mem[c][k] = DW'($urandom);
      run_pass(2, n);
      check_writes();
      check("done_pulses_random", done_cnt, 1);
    end

    // Abort while write (1,1) is presented.
    load_table();
    done_cnt = 0;
    hit = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_en && wr_class == 1 && wr_chunk == 1) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("abort_point_reached", hit, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_done", done, 0);
    check("abort_rd_class", rd_class, 0);
    check("abort_rd_chunk", rd_chunk, 0);
    check("abort_wr_class", wr_class, 0);
    check("abort_wr_chunk", wr_chunk, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    run_pass(0, n);
    check("latency_after_abort", n, N + 2);
    check_writes();

    // Abort together with start in IDLE: stays idle.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    check("abort_start_rd_en", rd_en, 0);

    // Synchronous reset mid-pass.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rd_en", rd_en, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_rd_class", rd_class, 0);
    check("midrst_rd_chunk", rd_chunk, 0);
    check("midrst_wr_class", wr_class, 0);
    check("midrst_wr_chunk", wr_chunk, 0);
    check("midrst_wr_data", wr_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", busy, 0);

`ifdef CLASS_BIN_POPCOUNT_EN
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NK; k++) mem[c][k] = pk(4, 4, 4, 4, 4, 4, 4, 4);
    run_pass(0, n);
    check("pc_pulses", pcq.size(), 2);
    for (int i = 0; i < pcq.size() && i < 2; i++) begin
      check($sformatf("pc%0d_count", i), pcq[i].cnt, NK * DIMS_PER_CC);
      check($sformatf("pc%0d_class", i), pcq[i].c, i);
      check($sformatf("pc%0d_chunk", i), pcq[i].k, NK - 1);
    end
    check("pc_hold", pc_count, NK * DIMS_PER_CC);
    check("pc_valid_idle", pc_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
